// File: rtl/mult_sched_if.sv
// Request/result bundle between the register-bus front end and the shared
// multiplier scheduler. The front end is the master; the scheduler is the slave.
interface mult_sched_if #(
  parameter int OPW  = 24,
  parameter int CNTW = 16
);
  logic            req0;
  logic [OPW-1:0]  a1_0;
  logic [OPW-1:0]  a2_0;
  logic            req1;
  logic [OPW-1:0]  a1_1;
  logic [OPW-1:0]  a2_1;
  logic            done0;
  logic            done1;
  logic [31:0]     res_w;
  logic [5:0]      res_l;
  logic [1:0]      res_b;
  logic            res_id;
  logic            busy;
  logic [CNTW-1:0] op_count;

  modport master (
    output req0, a1_0, a2_0, req1, a1_1, a2_1,
    input  done0, done1, res_w, res_l, res_b, res_id, busy, op_count
  );

  modport slave (
    input  req0, a1_0, a2_0, req1, a1_1, a2_1,
    output done0, done1, res_w, res_l, res_b, res_id, busy, op_count
  );
endinterface

// File: rtl/mult_sched.sv
// Two-channel round-robin scheduler around one serial OPW x OPW shift-add
// multiplier; posts the low product word, its popcount and status per grant.
module mult_sched #(
  parameter int OPW  = 24,
  parameter int CNTW = 16
) (
  input  logic        clk,
  input  logic        reset,
  mult_sched_if.slave bus
);
  localparam int ACCW  = 2 * OPW;
  localparam int STEPW = $clog2(OPW);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_POP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [STEPW-1:0] step_q, step_d;
  logic [OPW-1:0]  a1_q, a1_d;
  logic [OPW-1:0]  a2_q, a2_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic            id_q, id_d;
  logic            last_q, last_d;
  logic [31:0]     res_w_q, res_w_d;
  logic [5:0]      res_l_q, res_l_d;
  logic            valid_q, valid_d;
  logic            res_id_q, res_id_d;
  logic            done0_q, done0_d;
  logic            done1_q, done1_d;
  logic [CNTW-1:0] op_count_q, op_count_d;
  logic            grant_vld;
  logic            grant_ch;
  logic            step_last;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  // On a tie the channel not served last wins; a lone request always wins.
  assign grant_vld = bus.req0 | bus.req1;
  assign grant_ch  = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
  assign step_last = (step_q == STEPW'(OPW - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_vld) state_d = S_MULT;
      S_MULT:  if (step_last) state_d = S_POP;
      S_POP:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state_q != S_IDLE);
    bus.done0    = done0_q;
    bus.done1    = done1_q;
    bus.res_w    = res_w_q;
    bus.res_l    = res_l_q;
    bus.res_b    = {state_q == S_IDLE, valid_q};
    bus.res_id   = res_id_q;
    bus.op_count = op_count_q;
  end

  always_comb begin
    step_d     = step_q;
    a1_d       = a1_q;
    a2_d       = a2_q;
    acc_d      = acc_q;
    id_d       = id_q;
    last_d     = last_q;
    res_w_d    = res_w_q;
    res_l_d    = res_l_q;
    valid_d    = valid_q;
    res_id_d   = res_id_q;
    op_count_d = op_count_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          a1_d   = grant_ch ? bus.a1_1 : bus.a1_0;
          a2_d   = grant_ch ? bus.a2_1 : bus.a2_0;
          id_d   = grant_ch;
          acc_d  = '0;
          step_d = '0;
        end
      end
      S_MULT: begin
        if (a2_q[step_q]) acc_d = acc_q + (ACCW'(a1_q) << step_q);
        step_d = step_q + STEPW'(1);
      end
      S_POP: begin
        res_w_d    = acc_q[31:0];
        res_l_d    = popcount32(acc_q[31:0]);
        valid_d    = (acc_q[ACCW-1:32] == '0);
        res_id_d   = id_q;
        done0_d    = ~id_q;
        done1_d    = id_q;
        op_count_d = op_count_q + CNTW'(1);
        last_d     = id_q;
      end
      default: ;
    endcase
  end

  // Operand/accumulator path is not reset: it is reloaded on every grant.
  always_ff @(posedge clk) begin
    step_q <= step_d;
    a1_q   <= a1_d;
    a2_q   <= a2_d;
    acc_q  <= acc_d;
    id_q   <= id_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= 1'b1;
      res_w_q    <= '0;
      res_l_q    <= '0;
      valid_q    <= 1'b0;
      res_id_q   <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      op_count_q <= '0;
    end else begin
      last_q     <= last_d;
      res_w_q    <= res_w_d;
      res_l_q    <= res_l_d;
      valid_q    <= valid_d;
      res_id_q   <= res_id_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      op_count_q <= op_count_d;
    end
  end
endmodule

// File: doc/mult_sched.md
# mult_sched

Shared-multiplier scheduler for the GPIO emulator arithmetic path. Two requester channels share one serial 24×24 shift-add multiplier with a 32-bit popcount stage. Each grant runs a fixed-length operation and returns the product word (W), the ones count (L) and the status pair (B = {ready, valid}), tagged with the served channel. The block sits between the register-bus front end and the multiplier datapath. It replaces free-running per-write triggering with an explicit req/done handshake and round-robin arbitration.

## Interface

Parameters:
- OPW, 24: operand width; the product is 2·OPW bits.
- CNTW, 16: width of the completed-operation counter.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  channel 0 request (level); held high until done0 is seen.
- a1_0  input  OPW  channel 0 multiplicand; sampled at grant.
- a2_0  input  OPW  channel 0 multiplier; sampled at grant.
- req1  input  1  channel 1 request (level).
- a1_1  input  OPW  channel 1 multiplicand.
- a2_1  input  OPW  channel 1 multiplier.
- done0  output  1  one-cycle pulse when a channel 0 result is posted.
- done1  output  1  one-cycle pulse when a channel 1 result is posted.
- res_w  output  32  product bits [31:0] of the last completed operation.
- res_l  output  6  popcount of res_w (0..32).
- res_b  output  2  {ready, valid}; ready = not busy, valid = product[47:32] == 0 (registered).
- res_id  output  1  channel that owns the current res_* values.
- busy  output  1  high from grant until leaving DONE.
- op_count  output  CNTW  count of completed operations; wraps to 0.

## Operation

- States: IDLE, MULT, POP, DONE.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that channel.
  - If both are high, grant the channel not served last. The last-served pointer resets to 1, so ch0 wins the first tie.
  - On grant: latch both operands and the channel id, clear the 48-bit accumulator, clear the step counter, set busy, go to MULT.
- MULT runs 24 cycles. Step i (0..23) adds a1 << i to the accumulator when a2[i] = 1, then increments the step counter. After step 23, go to POP.
- POP runs 1 cycle:
  - res_w <= acc[31:0]
  - res_l <= popcount(acc[31:0])
  - valid <= (acc[47:32] == 0)
  - res_id <= granted channel
  - pulse the done line of the granted channel
  - op_count <= op_count + 1
  - update the last-served pointer
  - go to DONE
- DONE runs 1 cycle, done deasserts, then return to IDLE.
- res_* values hold until the next POP. Reads between operations are stable.
- req is not re-sampled during MULT, POP or DONE. A req dropped mid-operation does not abort it: the done pulse and op_count increment still occur.
- A requester must drop req within the cycle following its done pulse; otherwise it is re-granted under the round-robin rule.
- Arithmetic is unsigned. The accumulator is a full 48 bits with no truncation until POP.

## Timing

- Reset values: done0 = done1 = 0, res_w = 0, res_l = 0, res_b = 2'b10, res_id = 0, busy = 0, op_count = 0, state = IDLE, last-served = 1.
- Grant edge E0 is the edge at which IDLE samples req high. busy is high after E0.
- Edges E1..E24 are the MULT steps.
- Edge E25 is POP. res_* and op_count update and done rises after E25.
- Edge E26 is DONE. done falls and busy falls (res_b[1] = 1) after E26.
- Earliest next grant is E27. Period is 27 cycles per operation; latency from grant to done is 25 cycles.
- reset has priority over everything, including mid-operation: no done pulse and no count. All state returns to reset values at the next edge.
- Simultaneous req rise with an ongoing operation: the waiting channel is served at the next IDLE.
- op_count wraps from 2^CNTW−1 to 0.

## Test plan

- Reset with random inputs → all outputs at reset values, res_b = 2'b10; hold 5 cycles → no change.
- req0 with a1_0 = 3, a2_0 = 5 → done0 pulses exactly 25 cycles after grant; res_w = 0x0000000F, res_l = 4, res_b = 2'b11 after DONE, res_id = 0, op_count = 1.
- req1 with a1_1 = a2_1 = 0xFFFFFF → product 0xFFFFFE000001; res_w = 0xFE000001, res_l = 8, res_b[0] = 0, res_id = 1.
- req0 and req1 raised together after reset, both held until their done → ch0 served first, ch1 second (ch1 grant at E27 after ch0's grant); raise both again → ch0 served (last was ch1); op_count = 3.
- req0 with a1_0 = 0x123456, a2_0 = 0; assert reset at MULT step 10 → no done pulse, busy = 0 and op_count = 0 next cycle, res_w unchanged at 0.
- req0 with a1_0 = 0x000001, a2_0 = 0x800000 dropped at E5 → operation completes; done0 pulses; res_w = 0x00800000, res_l = 1, valid = 1.
